// File: rtl/regfile_port_arbiter.sv
// Two-client round-robin arbiter in front of the 8x8 register file.
// Grants at most one access per cycle, with a bounded lock that lets a
// client keep the grant for read-modify-write sequences. Drives the
// register file's read/write ports and returns registered read data.
module regfile_port_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rf_read_1,
  output logic [ADDR_W-1:0] rf_write,
  output logic              rf_write_signal,
  output logic [DATA_W-1:0] rf_in_data,
  input  logic [DATA_W-1:0] rf_out_data_1
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t            state, state_next;
  logic              last, last_next;
  logic [CNT_W-1:0]  lcnt, lcnt_next;
  logic [CNT_W-1:0]  lcnt_inc;
  logic              sel0, sel1;
  logic              hold0, hold1;

  logic              wr_go, rd_go;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign lcnt_inc = lcnt + ONE_C;

  // Arbitration: a lock owner that still requests wins outright, otherwise
  // a tie goes to the client that was not granted last.
  always_comb begin
    hold0 = (state == LOCK0) && req0;
    hold1 = (state == LOCK1) && req1;
    sel0  = 1'b0;
    sel1  = 1'b0;
    if (hold0) begin
      sel0 = 1'b1;
    end else if (hold1) begin
      sel1 = 1'b1;
    end else if (req0 && req1) begin
      sel0 = last;
      sel1 = !last;
    end else begin
      sel0 = req0;
      sel1 = req1;
    end
  end

  // State register: FSM state, round-robin pointer and lock counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      lcnt  <= '0;
    end else begin
      state <= state_next;
      last  <= last_next;
      lcnt  <= lcnt_next;
    end
  end

  // Next-state logic: enter or extend a lock, forcing release once the
  // owner has held the grant for LOCK_MAX consecutive cycles.
  always_comb begin
    state_next = IDLE;
    lcnt_next  = '0;
    last_next  = last;
    if (sel0) begin
      last_next = 1'b0;
      if (hold0) begin
        if (lock0 && (lcnt_inc < LOCK_MAX_C)) begin
          state_next = LOCK0;
          lcnt_next  = lcnt_inc;
        end
      end else if (lock0 && (ONE_C < LOCK_MAX_C)) begin
        state_next = LOCK0;
        lcnt_next  = ONE_C;
      end
    end else if (sel1) begin
      last_next = 1'b1;
      if (hold1) begin
        if (lock1 && (lcnt_inc < LOCK_MAX_C)) begin
          state_next = LOCK1;
          lcnt_next  = lcnt_inc;
        end
      end else if (lock1 && (ONE_C < LOCK_MAX_C)) begin
        state_next = LOCK1;
        lcnt_next  = ONE_C;
      end
    end
  end

  // Output logic: grants are suppressed while reset is held; the register
  // file ports follow the granted client and otherwise keep their last value.
  always_comb begin
    gnt0            = sel0 && rst_n;
    gnt1            = sel1 && rst_n;
    addr_sel        = gnt1 ? addr1 : addr0;
    wdata_sel       = gnt1 ? wdata1 : wdata0;
    wr_go           = (gnt0 && we0) || (gnt1 && we1);
    rd_go           = (gnt0 && !we0) || (gnt1 && !we1);
    rf_write_signal = wr_go && (addr_sel != '0);
    rf_write        = wr_go ? addr_sel  : wr_addr_q;
    rf_in_data      = wr_go ? wdata_sel : wdata_q;
    rf_read_1       = rd_go ? addr_sel  : rd_addr_q;
  end

  // Remember the last driven register file address/data so idle cycles
  // do not toggle the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
    end else begin
      if (rd_go) begin
        rd_addr_q <= addr_sel;
      end
      if (wr_go) begin
        wr_addr_q <= addr_sel;
        wdata_q   <= wdata_sel;
      end
    end
  end

  // Read response: one-cycle valid pulse, data held until the next read
  // for that client; register 0 always returns zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
      if (gnt0 && !we0) begin
        rdata0 <= (addr0 == '0) ? '0 : rf_out_data_1;
      end
      if (gnt1 && !we1) begin
        rdata1 <= (addr1 == '0) ? '0 : rf_out_data_1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 8x8 register
// file attached to the arbiter's register file ports.
module tb_regfile_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1, lock0, lock1, we0, we1;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic [2:0] rf_read_1, rf_write;
  logic       rf_write_signal;
  logic [7:0] rf_in_data, rf_out_data_1;

  logic [7:0] mem [8];

  int tests;
  int failures;

  typedef struct {
    logic       req0, req1, lock0, lock1, we0, we1;
    logic [2:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       exp_gnt0, exp_gnt1, exp_we;
    logic [2:0] exp_waddr;
    logic [7:0] exp_wdata;
    logic [2:0] exp_raddr;
    logic       exp_rv0, exp_rv1;
    logic [7:0] exp_rd0, exp_rd1;
  } vec_t;

  vec_t vecs [15];

  regfile_port_arbiter #(.DATA_W(8), .ADDR_W(3), .LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .rf_read_1(rf_read_1), .rf_write(rf_write),
    .rf_write_signal(rf_write_signal), .rf_in_data(rf_in_data),
    .rf_out_data_1(rf_out_data_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: synchronous write, combinational read.
  always @(posedge clk) begin
    if (rf_write_signal) mem[rf_write] <= rf_in_data;
  end
  assign rf_out_data_1 = mem[rf_read_1];

  function automatic vec_t mk(
    input logic r0, r1, l0, l1, w0, w1,
    input logic [2:0] a0, a1, input logic [7:0] d0, d1,
    input logic g0, g1, we, input logic [2:0] wa, input logic [7:0] wd,
    input logic [2:0] ra, input logic rv0, rv1, input logic [7:0] rd0, rd1);
    vec_t v;
    v.req0 = r0; v.req1 = r1; v.lock0 = l0; v.lock1 = l1;
    v.we0 = w0; v.we1 = w1; v.addr0 = a0; v.addr1 = a1;
    v.wdata0 = d0; v.wdata1 = d1;
    v.exp_gnt0 = g0; v.exp_gnt1 = g1; v.exp_we = we;
    v.exp_waddr = wa; v.exp_wdata = wd; v.exp_raddr = ra;
    v.exp_rv0 = rv0; v.exp_rv1 = rv1; v.exp_rd0 = rd0; v.exp_rd1 = rd1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    req0 = v.req0; req1 = v.req1; lock0 = v.lock0; lock1 = v.lock1;
    we0 = v.we0; we1 = v.we1; addr0 = v.addr0; addr1 = v.addr1;
    wdata0 = v.wdata0; wdata1 = v.wdata1;
  endtask

  task automatic idleInputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " gnt0"}, 32'(gnt0), 0);
    checkOutput({tag, " gnt1"}, 32'(gnt1), 0);
    checkOutput({tag, " rf_write_signal"}, 32'(rf_write_signal), 0);
    checkOutput({tag, " rf_read_1"}, 32'(rf_read_1), 0);
    checkOutput({tag, " rf_write"}, 32'(rf_write), 0);
    checkOutput({tag, " rf_in_data"}, 32'(rf_in_data), 0);
    checkOutput({tag, " rvalid0"}, 32'(rvalid0), 0);
    checkOutput({tag, " rvalid1"}, 32'(rvalid1), 0);
    checkOutput({tag, " rdata0"}, 32'(rdata0), 0);
    checkOutput({tag, " rdata1"}, 32'(rdata1), 0);
  endtask

  initial begin
    tests = 0;
    failures = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    idleInputs();

    //            r0 r1 l0 l1 w0 w1 a0 a1 d0     d1      g0 g1 we wa wd     ra  rv0 rv1 rd0    rd1
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00,  0, 0, 0, 0, 8'h00, 0,  0, 0, 8'h00, 8'h00);
    vecs[1]  = mk(1, 0, 0, 0, 1, 0, 3, 0, 8'h5A, 8'h00,  1, 0, 1, 3, 8'h5A, 0,  0, 0, 8'h00, 8'h00);
    vecs[2]  = mk(0, 1, 0, 0, 0, 0, 0, 3, 8'h00, 8'h00,  0, 1, 0, 3, 8'h5A, 3,  0, 1, 8'h00, 8'h5A);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00,  0, 0, 0, 3, 8'h5A, 3,  0, 0, 8'h00, 8'h5A);
    vecs[4]  = mk(1, 0, 0, 0, 1, 0, 2, 0, 8'h22, 8'h00,  1, 0, 1, 2, 8'h22, 3,  0, 0, 8'h00, 8'h5A);
    vecs[5]  = mk(0, 1, 0, 0, 0, 1, 0, 1, 8'h00, 8'h11,  0, 1, 1, 1, 8'h11, 3,  0, 0, 8'h00, 8'h5A);
    vecs[6]  = mk(1, 1, 0, 0, 0, 0, 1, 2, 8'h00, 8'h00,  1, 0, 0, 1, 8'h11, 1,  1, 0, 8'h11, 8'h5A);
    vecs[7]  = mk(1, 1, 0, 0, 0, 0, 1, 2, 8'h00, 8'h00,  0, 1, 0, 1, 8'h11, 2,  0, 1, 8'h11, 8'h22);
    vecs[8]  = mk(1, 1, 0, 0, 0, 0, 1, 2, 8'h00, 8'h00,  1, 0, 0, 1, 8'h11, 1,  1, 0, 8'h11, 8'h22);
    vecs[9]  = mk(1, 1, 0, 0, 0, 0, 1, 2, 8'h00, 8'h00,  0, 1, 0, 1, 8'h11, 2,  0, 1, 8'h11, 8'h22);
    vecs[10] = mk(1, 1, 0, 0, 0, 0, 1, 2, 8'h00, 8'h00,  1, 0, 0, 1, 8'h11, 1,  1, 0, 8'h11, 8'h22);
    vecs[11] = mk(1, 1, 0, 0, 0, 0, 1, 2, 8'h00, 8'h00,  0, 1, 0, 1, 8'h11, 2,  0, 1, 8'h11, 8'h22);
    vecs[12] = mk(0, 1, 0, 0, 0, 1, 0, 0, 8'h00, 8'hFF,  0, 1, 0, 0, 8'hFF, 2,  0, 0, 8'h11, 8'h22);
    vecs[13] = mk(0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00,  0, 1, 0, 0, 8'hFF, 0,  0, 1, 8'h11, 8'h00);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00,  0, 0, 0, 0, 8'hFF, 0,  0, 0, 8'h11, 8'h00);

    #12;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d gnt0", i), 32'(gnt0), 32'(vecs[i].exp_gnt0));
      checkOutput($sformatf("v%0d gnt1", i), 32'(gnt1), 32'(vecs[i].exp_gnt1));
      checkOutput($sformatf("v%0d rf_write_signal", i), 32'(rf_write_signal), 32'(vecs[i].exp_we));
      checkOutput($sformatf("v%0d rf_write", i), 32'(rf_write), 32'(vecs[i].exp_waddr));
      checkOutput($sformatf("v%0d rf_in_data", i), 32'(rf_in_data), 32'(vecs[i].exp_wdata));
      checkOutput($sformatf("v%0d rf_read_1", i), 32'(rf_read_1), 32'(vecs[i].exp_raddr));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d rvalid0", i), 32'(rvalid0), 32'(vecs[i].exp_rv0));
      checkOutput($sformatf("v%0d rvalid1", i), 32'(rvalid1), 32'(vecs[i].exp_rv1));
      checkOutput($sformatf("v%0d rdata0", i), 32'(rdata0), 32'(vecs[i].exp_rd0));
      checkOutput($sformatf("v%0d rdata1", i), 32'(rdata1), 32'(vecs[i].exp_rd1));
    end

    // Client 0 holds its lock with client 1 waiting: four grants, then forced release.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req0 = 1; lock0 = 1; we0 = 0; addr0 = 1;
      req1 = 1; lock1 = 0; we1 = 0; addr1 = 2;
      #1;
      checkOutput($sformatf("lockmax c%0d gnt0", c), 32'(gnt0), (c < 4) ? 1 : 0);
      checkOutput($sformatf("lockmax c%0d gnt1", c), 32'(gnt1), (c == 4) ? 1 : 0);
    end

    // Client 0 drops its lock after the second locked cycle; client 1 wins next.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req0 = 1; lock0 = (c == 0); req1 = 1; lock1 = 0;
      #1;
      checkOutput($sformatf("droplock c%0d gnt0", c), 32'(gnt0), (c == 2) ? 0 : 1);
      checkOutput($sformatf("droplock c%0d gnt1", c), 32'(gnt1), (c == 2) ? 1 : 0);
    end

    // Reset arrives while client 0 is mid-lock with a write on the port.
    @(negedge clk);
    idleInputs();
    req0 = 1; lock0 = 1; we0 = 1; addr0 = 5; wdata0 = 8'h77;
    #1;
    checkOutput("rstlock c0 gnt0", 32'(gnt0), 1);
    @(negedge clk);
    req1 = 1; we1 = 0; addr1 = 2;
    #1;
    checkOutput("rstlock c1 gnt0", 32'(gnt0), 1);
    checkOutput("rstlock c1 rf_write_signal", 32'(rf_write_signal), 1);
    checkOutput("rstlock c1 rf_write", 32'(rf_write), 5);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetState("rstlock asserted");
    @(negedge clk);
    #1;
    checkResetState("rstlock held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rstlock release gnt0", 32'(gnt0), 1);
    checkOutput("rstlock release gnt1", 32'(gnt1), 0);
    checkOutput("rstlock release rf_write_signal", 32'(rf_write_signal), 1);

    @(negedge clk);
    idleInputs();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
